// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches words at pc over req/ack, buffers {pc, instr} in a prefetch FIFO and closes the PC loop
// clock, reset_n          : rising-edge clock, synchronous active-low reset
// pc / pc_next            : current PC in, next PC out (held equal to pc while stalled)
// imem_req/addr/ack/rdata : single-outstanding word fetch handshake
// redirect_valid/target   : one-cycle branch/exception redirect, flushes the FIFO
// instr_valid/ready/data/pc : FIFO head towards decode
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  state_t state, state_nx;
  logic [31:0] stale_addr;
  logic [31:0] fifo_pc [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_after;
  logic push, pop, full;
  logic [31:0] target;
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];
  assign target = {redirect_target[31:2], 2'b00};
  assign full = count == (AW+1)'(DEPTH);
  assign instr_valid = count != '0;
  assign instr_pc = fifo_pc[rd_ptr];
  assign instr_data = fifo_data[rd_ptr];
  assign pop = instr_valid && instr_ready;
  // a response that coincides with a redirect belongs to the old path and is dropped
  assign push = state == FETCH && imem_ack && !redirect_valid;
  assign count_after = count + (AW+1)'(push) - (AW+1)'(pop);
  assign imem_req = state != IDLE;
  // the in-flight stale fetch keeps its address even though pc has moved to the target
  assign imem_addr = state == DISCARD ? stale_addr : {pc[31:2], 2'b00};
  assign pc_next = !reset_n ? RESET_PC :
                   redirect_valid ? target :
                   (state == FETCH && imem_ack) ? pc + 32'd4 : pc;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = (redirect_valid || !full || pop) ? FETCH : IDLE;
      FETCH:   state_nx = redirect_valid ? (imem_ack ? FETCH : DISCARD) :
                          (imem_ack && count_after == (AW+1)'(DEPTH)) ? IDLE : FETCH;
      DISCARD: state_nx = (imem_ack && !redirect_valid) ? FETCH : DISCARD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      stale_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && redirect_valid && !imem_ack) stale_addr <= {pc[31:2], 2'b00};
      if (redirect_valid) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_after;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr] <= pc;
      fifo_data[wr_ptr] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: random and directed fetch traffic checked against a queue-level reference model
module tb_instruction_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clock = 0;
  logic reset_n = 0;
  logic [31:0] pc = RESET_PC;
  logic [31:0] pc_next, imem_addr, instr_data, instr_pc;
  logic [31:0] imem_rdata = '0;
  logic [31:0] redirect_target = '0;
  logic imem_req, instr_valid;
  logic imem_ack = 0;
  logic redirect_valid = 0;
  logic instr_ready = 0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {logic [31:0] pc; logic [31:0] data;} entry_t;
  entry_t q[$];
  logic exp_req = 0;
  bit tainted = 0;
  logic [31:0] stale = '0;
  bit busy = 0;
  int wait_cnt = 0;
  int lat_mode = 0;
  always #5 clock = ~clock;
  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset_n(reset_n), .pc(pc), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  task automatic cycle(input bit rd, input logic [31:0] tgt, input bit rdy, input bit rst);
    logic [31:0] exp_pcn;
    bit pop, keep, req_old;
    int sz;
    @(negedge clock);
    reset_n = !rst;
    instr_ready = rdy;
    imem_ack = 0;
    if (!rst && imem_req === 1'b1) begin
      if (!busy) begin
        busy = 1;
        wait_cnt = lat_mode < 0 ? int'($urandom_range(0, 3)) : lat_mode;
      end
      imem_ack = wait_cnt == 0;
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    if (rd && imem_ack && tainted) rd = 0;
    rd = rd && !rst;
    redirect_valid = rd;
    redirect_target = tgt;
    keep = 0;
    exp_pcn = RESET_PC;
    #1;
    if (rst) check("pc_next_rst", pc_next, RESET_PC);
    else begin
      check("instr_valid", instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("instr_pc", instr_pc, q[0].pc);
        check("instr_data", instr_data, q[0].data);
      end
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, tainted ? stale : {pc[31:2], 2'b00});
      keep = exp_req && imem_ack && !tainted && !rd;
      exp_pcn = rd ? {tgt[31:2], 2'b00} : keep ? pc + 32'd4 : pc;
      check("pc_next", pc_next, exp_pcn);
    end
    @(posedge clock);
    #1;
    if (rst) begin
      q.delete();
      exp_req = 0;
      tainted = 0;
      busy = 0;
      pc = RESET_PC;
    end else begin
      sz = q.size();
      pop = sz != 0 && rdy;
      req_old = exp_req;
      if (pop) void'(q.pop_front());
      if (rd) q.delete();
      else if (keep) q.push_back('{pc, mem_word(pc)});
      if (rd && req_old && !imem_ack) begin
        if (!tainted) stale = {pc[31:2], 2'b00};
        tainted = 1;
      end else if (imem_ack) tainted = 0;
      if (rd) exp_req = 1;
      else if (req_old) exp_req = !(keep && q.size() == DEPTH);
      else exp_req = sz < DEPTH || pop;
      if (imem_ack) busy = 0;
      else if (busy) wait_cnt--;
      pc = exp_pcn;
    end
  endtask
  task automatic do_reset();
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
  endtask
  initial begin
    do_reset();
    lat_mode = 0;
    repeat (12) cycle(0, '0, 1, 0);
    do_reset();
    repeat (10) cycle(0, '0, 0, 0);
    check("full_pc", pc, 32'h10);
    check("full_req", imem_req, 1'b0);
    repeat (10) cycle(0, '0, 1, 0);
    do_reset();
    lat_mode = 3;
    cycle(0, '0, 1, 0);
    cycle(1, 32'h100, 1, 0);
    repeat (14) cycle(0, '0, 1, 0);
    do_reset();
    lat_mode = 0;
    repeat (3) cycle(0, '0, 1, 0);
    cycle(1, 32'h200, 1, 0);
    repeat (6) cycle(0, '0, 1, 0);
    cycle(1, 32'hFFFF_FFFC, 1, 0);
    repeat (6) cycle(0, '0, 1, 0);
    do_reset();
    lat_mode = 1;
    repeat (6) cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 1);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    repeat (8) cycle(0, '0, 1, 0);
    do_reset();
    lat_mode = -1;
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 11) == 0, $urandom, (i / 200) % 3 == 1 ? $urandom_range(0, 5) == 0 : $urandom_range(0, 3) != 0,
            $urandom_range(0, 499) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly downstream of the program counter register. It consumes the current PC, issues word fetches to instruction memory over a req/ack handshake, and buffers {pc, instruction} pairs in a small prefetch FIFO for decode. It also closes the PC loop by computing pc_next, which feeds the PC register input. The PC register loads unconditionally every clock, so this block holds pc_next equal to pc whenever it stalls.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, pc_next value driven while reset is asserted

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
pc  in  32  current PC from the PC register
pc_next  out  32  next PC to the PC register input
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch word address, bits [1:0] always 0
imem_ack  in  1  memory completion; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
redirect_valid  in  1  branch or exception redirect, one-cycle pulse
redirect_target  in  32  redirect address, bits [1:0] ignored (forced 0)
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode accepts head
instr_data  out  32  head instruction
instr_pc  out  32  address of head instruction

Behaviour:
- Reset (sampled at clock edge with reset_n=0):
  - state=IDLE; FIFO count=0; imem_req=0; instr_valid=0.
  - pc_next=RESET_PC combinationally while reset_n=0.
  - Any outstanding request is abandoned. Instruction memory shares this reset.
- FSM states:
  - IDLE: imem_req=0. Move to FETCH when count<DEPTH, or when count==DEPTH and a pop occurs this cycle.
  - FETCH: imem_req=1, imem_addr={pc[31:2],2'b00}. pc is stable because pc_next=pc until ack.
    - On imem_ack: push {pc, imem_rdata} and set pc_next=pc+4 (mod 2^32; 0xFFFFFFFC wraps to 0).
    - After the push, stay in FETCH if post-push/post-pop count<DEPTH, else go to IDLE.
    - Without ack: hold all outputs.
  - DISCARD: imem_req=1, imem_addr=stale_addr (captured at redirect). On imem_ack, drop imem_rdata and go to FETCH.
- pc_next priority:
  - reset: RESET_PC
  - redirect_valid: {redirect_target[31:2],2'b00}
  - FETCH && imem_ack: pc+4
  - otherwise: pc
- Redirect (highest priority after reset):
  - FIFO flushed in the same cycle; count=0 next cycle.
  - FETCH without ack: capture stale_addr=pc, go to DISCARD. The request is never withdrawn mid-handshake.
  - FETCH with ack in the same cycle: response dropped (no push), stay in FETCH.
  - IDLE: go to FETCH.
  - DISCARD: stay in DISCARD. stale_addr is unchanged and the new target is loaded.
- FIFO:
  - instr_valid=(count!=0); head drives instr_data and instr_pc.
  - Pop when instr_valid && instr_ready.
  - Simultaneous push and pop: count unchanged.
  - Pop in the same cycle as a redirect: the pop completes, then the flush applies.
  - No push ever occurs when full, because no request is issued when full.
- Latency:
  - Ack in cycle t makes the entry visible at instr_valid in cycle t+1.
  - Zero-wait memory with ready=1 sustains one instruction per cycle after the IDLE→FETCH cycle.
- At most one outstanding request. imem_addr is stable while imem_req=1.

Test Plan:
1. Reset release; ack=1 every cycle; ready=1 -> imem_addr 0x0,0x4,0x8,… on consecutive cycles; instr_valid first high 2 cycles after release with instr_pc=0x0; instr_pc increments by 4 with no bubbles.
2. ready=0; ack=1 -> exactly DEPTH=4 entries pushed (pc 0x0..0xC); imem_req drops; pc holds 0x10; ready=1 -> pops in order 0x0,0x4,0x8,0xC, and fetching resumes at 0x10.
3. Ack delayed 3 cycles; redirect to 0x100 in the first wait cycle -> FIFO empty next cycle; imem_addr stays at the old address until ack; that data is never visible; next imem_addr=0x100; first instr_pc=0x100.
4. Redirect to 0x200 in the same cycle as ack at 0x8 -> word at 0x8 never pushed; pc_next=0x200; next request addr 0x200.
5. Redirect to 0xFFFFFFFC; ack -> pc_next=0x0; following request addr 0x0; instr_pc sequence 0xFFFFFFFC then 0x0.
6. reset_n=0 for one cycle mid-FETCH with 2 entries buffered -> next cycle imem_req=0 and instr_valid=0; pc_next=RESET_PC during reset; fetch restarts at 0x0.
